pu_riscv_memdispatch: RTL and testbench

Registered dispatch stage directly downstream of the physical-memory-attribute checker. It captures one qualified memory request together with the checker's verdict (exception, misaligned, cache/ext/TCM routing). It then drives exactly one of three target channels (cache, external bus interface, TCM) with a held request and returns a single registered response to the core. A PMA fault or misalignment is answered locally, without issuing any target request.

---
 rtl/pu_riscv_pkg.sv | 28 ++
 rtl/pu_riscv_memdispatch_tgtmux.sv | 36 +++
 rtl/pu_riscv_memdispatch.sv | 178 +++++++++++++++++
 tb/tb_pu_riscv_memdispatch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pu_riscv_pkg.sv
// pu_riscv_pkg: shared encodings for the memory dispatch stage (biu sizes, dispatch FSM, target select)
// No ports; imported by pu_riscv_memdispatch and pu_riscv_memdispatch_tgtmux.
package pu_riscv_pkg;
    localparam logic [2:0] BYTE  = 3'b000;
    localparam logic [2:0] HWORD = 3'b001;
    localparam logic [2:0] WORD  = 3'b010;
    localparam logic [2:0] DWORD = 3'b011;
    localparam logic [2:0] QWORD = 3'b100;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_CACHE = 3'd1,
        WAIT_EXT   = 3'd2,
        WAIT_TCM   = 3'd3,
        FAULT      = 3'd4
    } dispatch_state_t;

    typedef enum logic [1:0] {
        TGT_CACHE = 2'd0,
        TGT_EXT   = 2'd1,
        TGT_TCM   = 2'd2
    } tgt_sel_t;

    // Maps a waiting state onto the target channel it talks to
    function automatic tgt_sel_t state2tgt(input dispatch_state_t s);
        return s == WAIT_EXT ? TGT_EXT : s == WAIT_TCM ? TGT_TCM : TGT_CACHE;
    endfunction
endpackage

// File: rtl/pu_riscv_memdispatch_tgtmux.sv
// pu_riscv_memdispatch_tgtmux: demuxes the held request onto one target and muxes that target's response back
// Ports: sel_i/active_i choose and enable a target; *_req_o per-target requests;
//        *_ack_i/*_q_i/*_err_i target responses; ack_o/q_o/err_o selected response (combinational).
module pu_riscv_memdispatch_tgtmux
    import pu_riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  tgt_sel_t          sel_i,
    input  logic              active_i,
    output logic              cache_req_o,
    output logic              ext_req_o,
    output logic              tcm_req_o,
    input  logic              cache_ack_i,
    input  logic              ext_ack_i,
    input  logic              tcm_ack_i,
    input  logic [XLEN-1:0]   cache_q_i,
    input  logic [XLEN-1:0]   ext_q_i,
    input  logic [XLEN-1:0]   tcm_q_i,
    input  logic              cache_err_i,
    input  logic              ext_err_i,
    input  logic              tcm_err_i,
    output logic              ack_o,
    output logic [XLEN-1:0]   q_o,
    output logic              err_o
);
    always_comb begin
        cache_req_o = active_i && sel_i == TGT_CACHE;
        ext_req_o   = active_i && sel_i == TGT_EXT;
        tcm_req_o   = active_i && sel_i == TGT_TCM;
        // Acks from channels not being driven are ignored
        ack_o = active_i && (sel_i == TGT_EXT ? ext_ack_i : sel_i == TGT_TCM ? tcm_ack_i : cache_ack_i);
        q_o   = sel_i == TGT_EXT ? ext_q_i : sel_i == TGT_TCM ? tcm_q_i : cache_q_i;
        err_o = sel_i == TGT_EXT ? ext_err_i : sel_i == TGT_TCM ? tcm_err_i : cache_err_i;
    end
endmodule

// File: rtl/pu_riscv_memdispatch.sv
// pu_riscv_memdispatch: registered dispatch of one PMA-checked memory request to cache, external bus or TCM
// Ports: clk_i/rst_ni clock and sync active-low reset; req_i/adr_i/size_i/lock_i/we_i/d_i core request;
//        kill_i flush; exception_i/misaligned_i/is_*_access_i checker verdict; stall_o not-accepting;
//        ack_o/q_o/err_o/misaligned_o registered response; tgt_*_o held shared request bus;
//        cache/ext/tcm _req_o/_ack_i/_q_i/_err_i per-target handshake.
module pu_riscv_memdispatch
    import pu_riscv_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PLEN = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [PLEN-1:0]   adr_i,
    input  logic [2:0]        size_i,
    input  logic              lock_i,
    input  logic              we_i,
    input  logic [XLEN-1:0]   d_i,
    input  logic              kill_i,
    input  logic              exception_i,
    input  logic              misaligned_i,
    input  logic              is_cache_access_i,
    input  logic              is_ext_access_i,
    input  logic              is_tcm_access_i,
    output logic              stall_o,
    output logic              ack_o,
    output logic [XLEN-1:0]   q_o,
    output logic              err_o,
    output logic              misaligned_o,
    output logic [PLEN-1:0]   tgt_adr_o,
    output logic [2:0]        tgt_size_o,
    output logic              tgt_lock_o,
    output logic              tgt_we_o,
    output logic [XLEN-1:0]   tgt_d_o,
    output logic              cache_req_o,
    output logic              ext_req_o,
    output logic              tcm_req_o,
    input  logic              cache_ack_i,
    input  logic              ext_ack_i,
    input  logic              tcm_ack_i,
    input  logic [XLEN-1:0]   cache_q_i,
    input  logic [XLEN-1:0]   ext_q_i,
    input  logic [XLEN-1:0]   tcm_q_i,
    input  logic              cache_err_i,
    input  logic              ext_err_i,
    input  logic              tcm_err_i
);
    dispatch_state_t state_q, state_d;
    logic              killed_q, killed_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              mis_q, mis_d;
    logic [XLEN-1:0]   q_q, q_d;
    logic              fault_err_q, fault_err_d;
    logic              fault_mis_q, fault_mis_d;
    logic [PLEN-1:0]   adr_q, adr_d;
    logic [2:0]        size_q, size_d;
    logic              lock_q, lock_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   d_q, d_d;
    logic              accept, any_route, waiting, drop;
    logic              mux_ack, mux_err;
    logic [XLEN-1:0]   mux_q;

    assign waiting   = state_q == WAIT_CACHE || state_q == WAIT_EXT || state_q == WAIT_TCM;
    assign accept    = state_q == IDLE && req_i && !kill_i;
    assign any_route = is_cache_access_i | is_ext_access_i | is_tcm_access_i;
    // A kill arriving in the ack cycle itself also suppresses the response
    assign drop      = killed_q | kill_i;

    pu_riscv_memdispatch_tgtmux #(.XLEN(XLEN)) u_tgtmux (
        .sel_i       (state2tgt(state_q)),
        .active_i    (waiting),
        .cache_req_o (cache_req_o),
        .ext_req_o   (ext_req_o),
        .tcm_req_o   (tcm_req_o),
        .cache_ack_i (cache_ack_i),
        .ext_ack_i   (ext_ack_i),
        .tcm_ack_i   (tcm_ack_i),
        .cache_q_i   (cache_q_i),
        .ext_q_i     (ext_q_i),
        .tcm_q_i     (tcm_q_i),
        .cache_err_i (cache_err_i),
        .ext_err_i   (ext_err_i),
        .tcm_err_i   (tcm_err_i),
        .ack_o       (mux_ack),
        .q_o         (mux_q),
        .err_o       (mux_err)
    );

    always_comb begin
        state_d     = state_q;
        killed_d    = killed_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        mis_d       = 1'b0;
        q_d         = q_q;
        fault_err_d = fault_err_q;
        fault_mis_d = fault_mis_q;
        adr_d       = accept ? adr_i  : adr_q;
        size_d      = accept ? size_i : size_q;
        lock_d      = accept ? lock_i : lock_q;
        we_d        = accept ? we_i   : we_q;
        d_d         = accept ? d_i    : d_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = (exception_i || misaligned_i || !any_route) ? FAULT :
                          is_cache_access_i ? WAIT_CACHE :
                          is_ext_access_i   ? WAIT_EXT   : WAIT_TCM;
                // An unrouted (but aligned) access is reported as an access fault
                fault_err_d = exception_i | (!misaligned_i & !any_route);
                fault_mis_d = misaligned_i;
            end
            WAIT_CACHE, WAIT_EXT, WAIT_TCM: begin
                killed_d = drop;
                if (mux_ack) begin
                    state_d  = IDLE;
                    killed_d = 1'b0;
                    ack_d    = !drop;
                    err_d    = !drop & mux_err;
                    q_d      = drop ? q_q : mux_q;
                end
            end
            FAULT: begin
                state_d = IDLE;
                ack_d   = !kill_i;
                err_d   = !kill_i & fault_err_q;
                mis_d   = !kill_i & fault_mis_q;
                q_d     = kill_i ? q_q : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            killed_q    <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            mis_q       <= 1'b0;
            q_q         <= '0;
            fault_err_q <= 1'b0;
            fault_mis_q <= 1'b0;
            adr_q       <= '0;
            size_q      <= '0;
            lock_q      <= 1'b0;
            we_q        <= 1'b0;
            d_q         <= '0;
        end else begin
            state_q     <= state_d;
            killed_q    <= killed_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            mis_q       <= mis_d;
            q_q         <= q_d;
            fault_err_q <= fault_err_d;
            fault_mis_q <= fault_mis_d;
            adr_q       <= adr_d;
            size_q      <= size_d;
            lock_q      <= lock_d;
            we_q        <= we_d;
            d_q         <= d_d;
        end
    end

    assign stall_o      = state_q != IDLE;
    assign ack_o        = ack_q;
    assign err_o        = err_q;
    assign misaligned_o = mis_q;
    assign q_o          = q_q;
    assign tgt_adr_o    = adr_q;
    assign tgt_size_o   = size_q;
    assign tgt_lock_o   = lock_q;
    assign tgt_we_o     = we_q;
    assign tgt_d_o      = d_q;
endmodule

// File: tb/tb_pu_riscv_memdispatch.sv
// tb_pu_riscv_memdispatch: directed self-checking bench for pu_riscv_memdispatch
module tb_pu_riscv_memdispatch;
    logic        clk_i = 1'b0;
    logic        rst_ni, req_i, lock_i, we_i, kill_i, exception_i, misaligned_i;
    logic        is_cache_access_i, is_ext_access_i, is_tcm_access_i;
    logic [63:0] adr_i, d_i, q_o, tgt_adr_o, tgt_d_o, cache_q_i, ext_q_i, tcm_q_i;
    logic [2:0]  size_i, tgt_size_o;
    logic        stall_o, ack_o, err_o, misaligned_o, tgt_lock_o, tgt_we_o;
    logic        cache_req_o, ext_req_o, tcm_req_o, cache_ack_i, ext_ack_i, tcm_ack_i;
    logic        cache_err_i, ext_err_i, tcm_err_i;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk_i = ~clk_i;

    pu_riscv_memdispatch #(.XLEN(64), .PLEN(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .adr_i(adr_i), .size_i(size_i),
        .lock_i(lock_i), .we_i(we_i), .d_i(d_i), .kill_i(kill_i), .exception_i(exception_i),
        .misaligned_i(misaligned_i), .is_cache_access_i(is_cache_access_i),
        .is_ext_access_i(is_ext_access_i), .is_tcm_access_i(is_tcm_access_i),
        .stall_o(stall_o), .ack_o(ack_o), .q_o(q_o), .err_o(err_o), .misaligned_o(misaligned_o),
        .tgt_adr_o(tgt_adr_o), .tgt_size_o(tgt_size_o), .tgt_lock_o(tgt_lock_o),
        .tgt_we_o(tgt_we_o), .tgt_d_o(tgt_d_o), .cache_req_o(cache_req_o),
        .ext_req_o(ext_req_o), .tcm_req_o(tcm_req_o), .cache_ack_i(cache_ack_i),
        .ext_ack_i(ext_ack_i), .tcm_ack_i(tcm_ack_i), .cache_q_i(cache_q_i),
        .ext_q_i(ext_q_i), .tcm_q_i(tcm_q_i), .cache_err_i(cache_err_i),
        .ext_err_i(ext_err_i), .tcm_err_i(tcm_err_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_i = 0; kill_i = 0; exception_i = 0; misaligned_i = 0; lock_i = 0; we_i = 0;
        is_cache_access_i = 0; is_ext_access_i = 0; is_tcm_access_i = 0;
        cache_ack_i = 0; ext_ack_i = 0; tcm_ack_i = 0;
        cache_err_i = 0; ext_err_i = 0; tcm_err_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        adr_i = 0; d_i = 0; size_i = 0; cache_q_i = 0; ext_q_i = 0; tcm_q_i = 0;
        rst_ni = 0;
        tick(); tick();
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_o); end n_chk++;
        if ({ack_o, err_o, misaligned_o} !== 3'b000) begin n_fail++; $display("FAIL reset_resp: got %b want 000", {ack_o, err_o, misaligned_o}); end n_chk++;
        if ({cache_req_o, ext_req_o, tcm_req_o} !== 3'b000) begin n_fail++; $display("FAIL reset_req: got %b want 000", {cache_req_o, ext_req_o, tcm_req_o}); end n_chk++;
        if (q_o !== 64'h0 || tgt_adr_o !== 64'h0 || tgt_d_o !== 64'h0) begin n_fail++; $display("FAIL reset_data: q %h adr %h d %h want 0", q_o, tgt_adr_o, tgt_d_o); end n_chk++;
        rst_ni = 1;
        tick();
    endtask

    task automatic test_cache_read();
        int hi = 0;
        int other = 0;
        req_i = 1; adr_i = 64'h8000_0000; size_i = 3'b010; we_i = 0; lock_i = 1; d_i = 64'h1234;
        is_cache_access_i = 1;
        tick();
        req_i = 0; is_cache_access_i = 0;
        if (stall_o !== 1'b1) begin n_fail++; $display("FAIL cache_stall: got %b want 1", stall_o); end n_chk++;
        if (tgt_adr_o !== 64'h8000_0000 || tgt_size_o !== 3'b010 || tgt_lock_o !== 1'b1 || tgt_we_o !== 1'b0) begin
            n_fail++; $display("FAIL cache_tgt_bus: adr %h size %b lock %b we %b want 80000000/010/1/0", tgt_adr_o, tgt_size_o, tgt_lock_o, tgt_we_o);
        end n_chk++;
        for (int i = 0; i < 3; i++) begin
            hi += int'(cache_req_o);
            other += int'(ext_req_o | tcm_req_o);
            if (i < 2) tick();
        end
        cache_ack_i = 1; cache_q_i = 64'hDEAD_BEEF;
        tick();
        cache_ack_i = 0;
        if (hi !== 3 || other !== 0) begin n_fail++; $display("FAIL cache_req_len: high %0d others %0d want 3/0", hi, other); end n_chk++;
        if (ack_o !== 1'b1 || err_o !== 1'b0) begin n_fail++; $display("FAIL cache_ack: ack %b err %b want 1/0", ack_o, err_o); end n_chk++;
        if (q_o !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL cache_q: got %h want deadbeef", q_o); end n_chk++;
        if (cache_req_o !== 1'b0 || stall_o !== 1'b0) begin n_fail++; $display("FAIL cache_release: req %b stall %b want 0/0", cache_req_o, stall_o); end n_chk++;
        cache_q_i = 64'h0;
        tick();
        if (ack_o !== 1'b0 || q_o !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL cache_hold: ack %b q %h want 0/deadbeef", ack_o, q_o); end n_chk++;
    endtask

    task automatic test_pma_exception();
        req_i = 1; exception_i = 1; we_i = 1; is_cache_access_i = 1; adr_i = 64'h10;
        tick();
        idle_inputs();
        if (stall_o !== 1'b1 || ack_o !== 1'b0) begin n_fail++; $display("FAIL exc_fault_cycle: stall %b ack %b want 1/0", stall_o, ack_o); end n_chk++;
        if ({cache_req_o, ext_req_o, tcm_req_o} !== 3'b000) begin n_fail++; $display("FAIL exc_no_req: got %b want 000", {cache_req_o, ext_req_o, tcm_req_o}); end n_chk++;
        tick();
        if ({ack_o, err_o, misaligned_o} !== 3'b110) begin n_fail++; $display("FAIL exc_resp: got %b want 110", {ack_o, err_o, misaligned_o}); end n_chk++;
        if (q_o !== 64'h0 || stall_o !== 1'b0) begin n_fail++; $display("FAIL exc_q: q %h stall %b want 0/0", q_o, stall_o); end n_chk++;
        tick();
        if (ack_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL exc_pulse: ack %b err %b want 0/0", ack_o, err_o); end n_chk++;
    endtask

    task automatic test_mis_exc();
        req_i = 1; exception_i = 1; misaligned_i = 1; is_ext_access_i = 1; adr_i = 64'h13;
        tick();
        idle_inputs();
        if (ext_req_o !== 1'b0) begin n_fail++; $display("FAIL misexc_no_req: got %b want 0", ext_req_o); end n_chk++;
        tick();
        if ({ack_o, err_o, misaligned_o} !== 3'b111) begin n_fail++; $display("FAIL misexc_resp: got %b want 111", {ack_o, err_o, misaligned_o}); end n_chk++;
        tick();
        if ({ack_o, err_o, misaligned_o} !== 3'b000) begin n_fail++; $display("FAIL misexc_pulse: got %b want 000", {ack_o, err_o, misaligned_o}); end n_chk++;
        req_i = 1; misaligned_i = 1; is_tcm_access_i = 1;
        tick();
        idle_inputs();
        tick();
        if ({ack_o, err_o, misaligned_o} !== 3'b101) begin n_fail++; $display("FAIL mis_only_resp: got %b want 101", {ack_o, err_o, misaligned_o}); end n_chk++;
    endtask

    task automatic test_no_route();
        req_i = 1; adr_i = 64'h20;
        tick();
        idle_inputs();
        if (stall_o !== 1'b1 || {cache_req_o, ext_req_o, tcm_req_o} !== 3'b000) begin n_fail++; $display("FAIL noroute_fault: stall %b req %b want 1/000", stall_o, {cache_req_o, ext_req_o, tcm_req_o}); end n_chk++;
        tick();
        if ({ack_o, err_o, misaligned_o} !== 3'b110) begin n_fail++; $display("FAIL noroute_resp: got %b want 110", {ack_o, err_o, misaligned_o}); end n_chk++;
        tick();
    endtask

    task automatic test_back_to_back();
        req_i = 1; is_tcm_access_i = 1; adr_i = 64'h100; we_i = 1; d_i = 64'hAAAA;
        tick();
        if (tcm_req_o !== 1'b1 || tgt_d_o !== 64'hAAAA || tgt_we_o !== 1'b1) begin n_fail++; $display("FAIL b2b_tcm_req: req %b d %h we %b want 1/aaaa/1", tcm_req_o, tgt_d_o, tgt_we_o); end n_chk++;
        tcm_ack_i = 1; tcm_q_i = 64'h5555;
        is_tcm_access_i = 0; is_ext_access_i = 1; adr_i = 64'h200; we_i = 0;
        tick();
        tcm_ack_i = 0;
        if (ack_o !== 1'b1 || q_o !== 64'h5555 || stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_first_ack: ack %b q %h stall %b want 1/5555/0", ack_o, q_o, stall_o); end n_chk++;
        tick();
        if (ext_req_o !== 1'b1 || tcm_req_o !== 1'b0 || tgt_adr_o !== 64'h200 || ack_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second_req: ext %b tcm %b adr %h ack %b want 1/0/200/0", ext_req_o, tcm_req_o, tgt_adr_o, ack_o);
        end n_chk++;
        idle_inputs();
        ext_ack_i = 1; ext_q_i = 64'h7777;
        tick();
        ext_ack_i = 0;
        if (ack_o !== 1'b1 || q_o !== 64'h7777) begin n_fail++; $display("FAIL b2b_second_ack: ack %b q %h want 1/7777", ack_o, q_o); end n_chk++;
        tick();
    endtask

    task automatic test_kill();
        int acks = 0;
        req_i = 1; kill_i = 1; is_cache_access_i = 1;
        tick();
        if (stall_o !== 1'b0 || cache_req_o !== 1'b0) begin n_fail++; $display("FAIL kill_idle: stall %b req %b want 0/0", stall_o, cache_req_o); end n_chk++;
        idle_inputs();
        req_i = 1; is_ext_access_i = 1; adr_i = 64'h300;
        tick();
        idle_inputs();
        kill_i = 1;
        tick();
        kill_i = 0;
        acks += int'(ack_o);
        if (ext_req_o !== 1'b1) begin n_fail++; $display("FAIL kill_req_held: got %b want 1", ext_req_o); end n_chk++;
        tick();
        acks += int'(ack_o);
        ext_ack_i = 1; ext_q_i = 64'h9999; ext_err_i = 1;
        tick();
        ext_ack_i = 0; ext_err_i = 0;
        acks += int'(ack_o);
        if (acks !== 0 || err_o !== 1'b0) begin n_fail++; $display("FAIL kill_no_ack: acks %0d err %b want 0/0", acks, err_o); end n_chk++;
        if (ext_req_o !== 1'b0 || stall_o !== 1'b0 || q_o !== 64'h7777) begin n_fail++; $display("FAIL kill_done: req %b stall %b q %h want 0/0/7777", ext_req_o, stall_o, q_o); end n_chk++;
        req_i = 1; is_cache_access_i = 1; adr_i = 64'h400;
        tick();
        idle_inputs();
        cache_ack_i = 1; cache_q_i = 64'h4242; cache_err_i = 1;
        tick();
        idle_inputs();
        if ({ack_o, err_o} !== 2'b11 || q_o !== 64'h4242) begin n_fail++; $display("FAIL kill_after: ack/err %b q %h want 11/4242", {ack_o, err_o}, q_o); end n_chk++;
        req_i = 1; exception_i = 1;
        tick();
        idle_inputs();
        kill_i = 1;
        tick();
        kill_i = 0;
        if ({ack_o, err_o} !== 2'b00) begin n_fail++; $display("FAIL kill_fault: ack/err %b want 00", {ack_o, err_o}); end n_chk++;
        tick();
    endtask

    task automatic test_reset_mid();
        req_i = 1; is_cache_access_i = 1; adr_i = 64'h500;
        tick();
        idle_inputs();
        if (cache_req_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %b want 1", cache_req_o); end n_chk++;
        rst_ni = 0;
        tick();
        rst_ni = 1;
        if ({cache_req_o, ext_req_o, tcm_req_o, stall_o, ack_o} !== 5'b00000) begin
            n_fail++; $display("FAIL rstmid_post: req/stall/ack %b want 00000", {cache_req_o, ext_req_o, tcm_req_o, stall_o, ack_o});
        end n_chk++;
        tick();
    endtask

    initial begin
        test_reset();
        test_cache_read();
        test_pma_exception();
        test_mis_exc();
        test_no_route();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
